// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
// PS2_MOUSE_RX_WHEEL_EN selects 4-byte IntelliMouse packets instead of 3-byte packets.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } frame_state_e;

`ifdef PS2_MOUSE_RX_WHEEL_EN
  localparam int PKT_BYTES = 4;
`else
  localparam int PKT_BYTES = 3;
`endif

  // Index of the final byte of a packet
  localparam logic [1:0] LAST_IDX = 2'(PKT_BYTES - 1);

  // Status byte bit that is always 1 in a well-aligned first byte
  localparam int SYNC_BIT = 3;

  // A frame is good when the stop bit is high and data plus parity has odd weight
  function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
    return stop & (^{data, par});
  endfunction

endpackage

// File: rtl/ps2_pin_filter.sv
// Two-flop synchroniser plus stable-count deglitch filter for one PS/2 pin.
// The output level only follows the pin after FILT_LEN consecutive ce samples disagree with it.
module ps2_pin_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic pin_i,
  output logic level_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous pin into the clk domain; idle bus level is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pin_i};
    end
  end

  // Count consecutive disagreeing samples and flip the level once the run is long enough
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (ce) begin
      if (sync_q[1] != level_q) begin
        if (cnt_q == CW'(FILT_LEN - 1)) begin
          level_d = sync_q[1];
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = {CW{1'b0}};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b1;
      cnt_q   <= {CW{1'b0}};
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: frame FSM, bit/packet timeouts and packet assembler.
// Define PS2_MOUSE_RX_WHEEL_EN for 4-byte packets and the extra wheel output.
module ps2_mouse_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int BIT_TMO  = 2000,
  parameter int PKT_TMO  = 20000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic [24:0] ps2_mouse,
`ifdef PS2_MOUSE_RX_WHEEL_EN
  output logic [7:0]  wheel,
`endif
  output logic        rx_err
);

  localparam int BTW = $clog2(BIT_TMO + 1);
  localparam int PTW = $clog2(PKT_TMO + 1);

  logic clk_filt_s, dat_filt_s, fedge_s;
  logic clk_prev_q;

  frame_state_e state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [BTW-1:0] bit_tmr_q, bit_tmr_d;
  logic [PTW-1:0] pkt_tmr_q, pkt_tmr_d;
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     pkt_q [PKT_BYTES];
  logic [7:0]     pkt_d [PKT_BYTES];
  logic           pub_q, pub_d;
  logic [24:0]    mouse_q, mouse_d;
  logic           err_q, err_d;
  logic           byte_ok_s;
`ifdef PS2_MOUSE_RX_WHEEL_EN
  logic [7:0]     wheel_q, wheel_d;
`endif

  ps2_pin_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk(clk), .reset_n(reset_n), .ce(ce), .pin_i(ps2_clk_i), .level_o(clk_filt_s)
  );

  ps2_pin_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk(clk), .reset_n(reset_n), .ce(ce), .pin_i(ps2_dat_i), .level_o(dat_filt_s)
  );

  assign fedge_s = clk_prev_q & ~clk_filt_s;

  // Frame FSM, timeouts and packet assembly next-state logic
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_tmr_d = bit_tmr_q;
    pkt_tmr_d = pkt_tmr_q;
    idx_d     = idx_q;
    pkt_d     = pkt_q;
    pub_d     = 1'b0;
    mouse_d   = mouse_q;
    err_d     = 1'b0;
    byte_ok_s = 1'b0;
`ifdef PS2_MOUSE_RX_WHEEL_EN
    wheel_d   = wheel_q;
`endif

    // Bit timer runs only inside a frame and reloads on every falling edge
    if ((state_q == IDLE) || fedge_s) begin
      bit_tmr_d = {BTW{1'b0}};
    end else if (ce && (bit_tmr_q != BTW'(BIT_TMO))) begin
      bit_tmr_d = bit_tmr_q + BTW'(1);
    end else begin
      bit_tmr_d = bit_tmr_q;
    end

    // Packet timer runs only between frames of a partially received packet
    if ((state_q == IDLE) && (idx_q != 2'd0)) begin
      if (ce && (pkt_tmr_q != PTW'(PKT_TMO))) begin
        pkt_tmr_d = pkt_tmr_q + PTW'(1);
      end else begin
        pkt_tmr_d = pkt_tmr_q;
      end
    end else begin
      pkt_tmr_d = {PTW{1'b0}};
    end

    // Frame FSM; a falling edge takes priority over an expiring bit timer
    if (fedge_s) begin
      case (state_q)
        IDLE: begin
          if (!dat_filt_s) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shift_d = {dat_filt_s, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = PAR;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        PAR: begin
          par_d   = dat_filt_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (frame_ok(shift_q, par_q, dat_filt_s)) begin
            byte_ok_s = 1'b1;
          end else begin
            err_d = 1'b1;
            idx_d = 2'd0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if ((state_q != IDLE) && (bit_tmr_q == BTW'(BIT_TMO))) begin
      state_d = IDLE;
      err_d   = 1'b1;
      idx_d   = 2'd0;
    end else begin
      state_d = state_q;
    end

    // Publish the completed packet one clk after its last byte was stored
    if (pub_q) begin
      mouse_d = {~mouse_q[24], pkt_q[2], pkt_q[1], pkt_q[0]};
`ifdef PS2_MOUSE_RX_WHEEL_EN
      wheel_d = pkt_q[3];
`endif
      idx_d   = 2'd0;
    end else if ((state_q == IDLE) && (idx_q != 2'd0) && (pkt_tmr_q == PTW'(PKT_TMO))) begin
      idx_d = 2'd0;
    end else begin
      mouse_d = mouse_q;
    end

    // Store an accepted byte; a misaligned first byte is dropped to regain sync
    if (byte_ok_s) begin
      if ((idx_q == 2'd0) && !shift_q[SYNC_BIT]) begin
        idx_d = 2'd0;
      end else begin
        pkt_d[idx_q] = shift_q;
        if (idx_q == LAST_IDX) begin
          pub_d = 1'b1;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
    end else begin
      pub_d = 1'b0;
    end
  end

  // State, timer, packet and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      bit_tmr_q  <= {BTW{1'b0}};
      pkt_tmr_q  <= {PTW{1'b0}};
      idx_q      <= 2'd0;
      for (int i = 0; i < PKT_BYTES; i++) begin
        pkt_q[i] <= 8'h00;
      end
      pub_q      <= 1'b0;
      mouse_q    <= 25'd0;
      err_q      <= 1'b0;
`ifdef PS2_MOUSE_RX_WHEEL_EN
      wheel_q    <= 8'h00;
`endif
    end else begin
      clk_prev_q <= clk_filt_s;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_tmr_q  <= bit_tmr_d;
      pkt_tmr_q  <= pkt_tmr_d;
      idx_q      <= idx_d;
      pkt_q      <= pkt_d;
      pub_q      <= pub_d;
      mouse_q    <= mouse_d;
      err_q      <= err_d;
`ifdef PS2_MOUSE_RX_WHEEL_EN
      wheel_q    <= wheel_d;
`endif
    end
  end

  assign ps2_mouse = mouse_q;
  assign rx_err    = err_q;
`ifdef PS2_MOUSE_RX_WHEEL_EN
  assign wheel     = wheel_q;
`endif

endmodule
